// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter: FSM state encoding and
// frame-shape constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 1042;
  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit so the FSM advances on the following edge.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = enable_i && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_baud_tick

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB-first, one stop bit.
// serial_tx and busy come straight from flops.
module uart_tx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       busy,
  output logic       serial_tx
);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 frame_start;
  logic                 bit_tick;
  logic [2:0]           next_idx;

  assign frame_start = (state_q == IDLE) && load;
  assign next_idx    = bit_idx_q + 3'd1;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .clear_i (frame_start),
    .enable_i(state_q != IDLE),
    .tick_o  (bit_tick)
  );

  // Next-state logic also computes the next line level, so the output flop
  // already holds the new bit in the first cycle of each bit period.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (load) begin
          shift_d   = data_in;
          bit_idx_d = 3'd0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d   = STOP;
            bit_idx_d = 3'd0;
            tx_d      = 1'b1;
          end else begin
            bit_idx_d = next_idx;
            tx_d      = shift_q[next_idx];
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            state_d   = IDLE;
            bit_idx_d = 3'd0;
            busy_d    = 1'b0;
          end else begin
            bit_idx_d = next_idx;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign serial_tx = tx_q;
  assign busy      = busy_q;

endmodule : uart_tx_8n1

// File: tb/tb_uart_tx_8n1.sv
// Directed bench for uart_tx_8n1 with a short bit period; line traces are
// recorded cycle by cycle from the acceptance edge and checked per scenario.
module tb_uart_tx_8n1;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       load;
  logic       busy;
  logic       serial_tx;

  int checks = 0;
  int errors = 0;

  logic tx_tr   [0:127];
  logic busy_tr [0:127];

  uart_tx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .load     (load),
    .busy     (busy),
    .serial_tx(serial_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records len cycles starting with the current one; optionally drops load
  // at release_at and pulses load with pulse_data at pulse_at.
  task automatic capture(input int len, input int release_at,
                         input int pulse_at, input logic [7:0] pulse_data);
    for (int i = 0; i < len; i++) begin
      tx_tr[i]   = serial_tx;
      busy_tr[i] = busy;
      if (i == release_at) load = 1'b0;
      if (pulse_at >= 0 && i == pulse_at + 1) load = 1'b0;
      if (i == pulse_at) begin
        load    = 1'b1;
        data_in = pulse_data;
      end
      if (i < len - 1) tick();
    end
  endtask

  // Line level of each of the 10 bit periods from base; X if it wavers.
  function automatic logic [0:9] frame_bits(input int base);
    logic [0:9] r;
    for (int k = 0; k < 10; k++) begin
      r[k] = tx_tr[base + k * CPB];
      for (int c = 1; c < CPB; c++)
        if (tx_tr[base + k * CPB + c] !== r[k]) r[k] = 1'bx;
    end
    return r;
  endfunction

  function automatic int busy_run(input int base);
    int n = 0;
    while (base + n < 128 && busy_tr[base + n] === 1'b1) n++;
    return n;
  endfunction

  function automatic int idle_violations(input int from, input int to);
    int n = 0;
    for (int i = from; i <= to; i++)
      if (tx_tr[i] !== 1'b1 || busy_tr[i] !== 1'b0) n++;
    return n;
  endfunction

  task automatic test_reset();
    logic [0:9] got;
    reset = 1'b1; load = 1'b1; data_in = 8'hFF;
    tick(); tick();
    checks++; if (serial_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", serial_tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0; load = 1'b0;
    tick();
    checks++; if (serial_tx !== 1'b1) begin errors++; $display("FAIL reset_load_ignored_tx: got %b expected 1", serial_tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_load_ignored_busy: got %b expected 0", busy); end
    got = '0;
    $display("test_reset done: serial_tx=%b busy=%b", serial_tx, busy);
  endtask

  task automatic test_single();
    logic [0:9] got;
    data_in = 8'hAA; load = 1'b1;
    tick();
    checks++; if (serial_tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_accept: got tx=%b busy=%b expected tx=0 busy=1", serial_tx, busy); end
    data_in = 8'h0F;
    capture(FRAME + 2 * CPB, 9, -1, 8'h00);
    got = frame_bits(0);
    checks++; if (got !== 10'b0010101011) begin errors++; $display("FAIL single_bits: got %b expected 0010101011", got); end
    checks++; if (busy_run(0) !== FRAME) begin errors++; $display("FAIL single_busy_len: got %0d expected %0d", busy_run(0), FRAME); end
    checks++; if (idle_violations(FRAME, FRAME + 2 * CPB - 1) !== 0) begin errors++; $display("FAIL single_no_extra: got %0d non-idle cycles expected 0", idle_violations(FRAME, FRAME + 2 * CPB - 1)); end
    $display("test_single: byte AA line %b", got);
  endtask

  task automatic test_second();
    logic [0:9] got;
    repeat (3) tick();
    data_in = 8'hFF; load = 1'b1;
    tick();
    load = 1'b0;
    capture(FRAME + 2, -1, -1, 8'h00);
    got = frame_bits(0);
    checks++; if (got !== 10'b0111111111) begin errors++; $display("FAIL second_bits: got %b expected 0111111111", got); end
    checks++; if (busy_run(0) !== FRAME) begin errors++; $display("FAIL second_busy_len: got %0d expected %0d", busy_run(0), FRAME); end
    checks++; if (busy_tr[FRAME + 1] !== 1'b0) begin errors++; $display("FAIL second_busy_end: got %b expected 0", busy_tr[FRAME + 1]); end
    $display("test_second: byte FF line %b", got);
  endtask

  task automatic test_lockout();
    logic [0:9] got;
    repeat (2) tick();
    data_in = 8'h3C; load = 1'b1;
    tick();
    load = 1'b0;
    capture(FRAME + 2 * CPB, -1, 15, 8'h00);
    got = frame_bits(0);
    checks++; if (got !== 10'b0001111001) begin errors++; $display("FAIL lockout_bits: got %b expected 0001111001", got); end
    checks++; if (busy_run(0) !== FRAME) begin errors++; $display("FAIL lockout_busy_len: got %0d expected %0d", busy_run(0), FRAME); end
    checks++; if (idle_violations(FRAME, FRAME + 2 * CPB - 1) !== 0) begin errors++; $display("FAIL lockout_no_extra: got %0d non-idle cycles expected 0", idle_violations(FRAME, FRAME + 2 * CPB - 1)); end
    $display("test_lockout: byte 3C line %b", got);
  endtask

  task automatic test_back_to_back();
    logic [0:9] got1, got2;
    repeat (2) tick();
    data_in = 8'h55; load = 1'b1;
    tick();
    capture(2 * (FRAME + 1), 2 * FRAME, -1, 8'h00);
    got1 = frame_bits(0);
    got2 = frame_bits(FRAME + 1);
    checks++; if (got1 !== 10'b0101010101) begin errors++; $display("FAIL held_bits1: got %b expected 0101010101", got1); end
    checks++; if (tx_tr[FRAME] !== 1'b1 || busy_tr[FRAME] !== 1'b0) begin errors++; $display("FAIL held_gap: got tx=%b busy=%b expected tx=1 busy=0", tx_tr[FRAME], busy_tr[FRAME]); end
    checks++; if (got2 !== 10'b0101010101) begin errors++; $display("FAIL held_bits2: got %b expected 0101010101", got2); end
    checks++; if (busy_run(FRAME + 1) !== FRAME) begin errors++; $display("FAIL held_busy_len2: got %0d expected %0d", busy_run(FRAME + 1), FRAME); end
    tick();
    checks++; if (busy !== 1'b0 || serial_tx !== 1'b1) begin errors++; $display("FAIL held_stop_after_release: got tx=%b busy=%b expected tx=1 busy=0", serial_tx, busy); end
    $display("test_back_to_back: frames %b / %b", got1, got2);
  endtask

  task automatic test_reset_mid();
    logic [0:9] got;
    repeat (2) tick();
    data_in = 8'hF0; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (2 * CPB + 1) tick();
    reset = 1'b1;
    tick();
    checks++; if (serial_tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b expected 1", serial_tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    tick();
    data_in = 8'hA5; load = 1'b1;
    tick();
    load = 1'b0;
    capture(FRAME + 2, -1, -1, 8'h00);
    got = frame_bits(0);
    checks++; if (got !== 10'b0101001011) begin errors++; $display("FAIL midreset_bits: got %b expected 0101001011", got); end
    checks++; if (busy_run(0) !== FRAME) begin errors++; $display("FAIL midreset_busy_len: got %0d expected %0d", busy_run(0), FRAME); end
    $display("test_reset_mid: byte A5 line %b", got);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; data_in = 8'h00;
    test_reset();
    test_single();
    test_second();
    test_lockout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_8n1
